digit_scan_driver: RTL and testbench

Time-multiplexed scan stage for a multi-digit display. It sits directly upstream of the per-digit decoder: holds a packed multi-digit BCD value, presents one 4-bit digit code per scan slot on `num`, and drives a one-hot digit enable. Value updates are double-buffered and applied only at frame boundaries, so a displayed frame is never torn. Non-BCD nibbles and optional leading zeros are replaced by a blank code.

---
 rtl/digit_scan_driver_if.sv | 22 ++
 rtl/digit_scan_driver.sv | 119 +++++++++++
 tb/tb_digit_scan_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_driver_if.sv
// Display-side bundle of the digit scan driver: the value/control inputs
// coming from the host logic and the scan outputs going to the decoder.
interface digit_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    blank_lz;
  logic [3:0]              num;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_start;

  modport master (
    output value_in, load, blank_lz,
    input  num, digit_en, frame_start
  );

  modport slave (
    input  value_in, load, blank_lz,
    output num, digit_en, frame_start
  );
endinterface

// File: rtl/digit_scan_driver.sv
// Time-multiplexed digit scanner. It holds a double-buffered BCD value,
// steps a one-hot enable across the digits, and presents each digit's code
// (with non-BCD and optional leading-zero blanking) to the downstream decoder.
module digit_scan_driver #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         REFRESH_DIV = 1000,
  parameter logic [3:0] BLANK_CODE  = 4'b1111
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_scan_driver_if.slave   bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_DIGIT0 = NUM_DIGITS'(1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [VW-1:0]         active_q, active_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_start_q, frame_start_d;
  logic                  adv;
  logic                  boundary;

  // Digit code for one slot: non-BCD nibbles blank first; leading-zero
  // blanking never applies to digit 0 so an all-zero value still shows "0".
  function automatic logic [3:0] digit_code(
    input logic [VW-1:0] val,
    input logic [IW-1:0] idx,
    input logic          blz
  );
    logic [3:0] nib;
    logic       upper_zero;
    nib        = val[4*int'(idx) +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx)) && (val[4*j +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    if (nib > 4'd9) begin
      return BLANK_CODE;
    end else if (blz && (idx != '0) && upper_zero) begin
      return BLANK_CODE;
    end
    return nib;
  endfunction

  // Next-state: prescaler/index stepping, frame-boundary buffer swap and
  // registered scan outputs computed from the post-swap value.
  always_comb begin
    adv           = (presc_q == PRESC_LAST);
    boundary      = adv && (idx_q == IDX_LAST);
    presc_d       = adv ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    active_d      = active_q;
    num_d         = num_q;
    digit_en_d    = digit_en_q;
    frame_start_d = boundary;

    if (adv) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The swap uses the flag as it was before this edge, so a load landing
    // on the boundary edge itself stays pending for one more frame.
    if (boundary && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end

    if (bus.load) begin
      pend_d     = bus.value_in;
      pend_vld_d = 1'b1;
    end

    if (adv) begin
      digit_en_d = EN_DIGIT0 << idx_d;
      num_d      = digit_code(active_d, idx_d, bus.blank_lz);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      active_q      <= '0;
      num_q         <= 4'd0;
      digit_en_q    <= EN_DIGIT0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      active_q      <= active_d;
      num_q         <= num_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.num         = num_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: directed scenarios plus a randomized phase,
// all checked every cycle against a frame/slot arithmetic reference model.
module tb_digit_scan_driver;

  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  digit_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  digit_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BLANK_CODE (4'b1111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the displayed code of digit k of value v.
  function automatic logic [3:0] ref_code(input logic [15:0] v, input int k, input logic blz);
    int rest;
    int d;
    rest = int'(v >> (4 * k));
    d    = rest % 16;
    if (d > 9) return 4'hF;
    if (blz && k > 0 && rest == 0) return 4'hF;
    return 4'(d);
  endfunction

  // Reference model: counts edges since reset and derives slot/frame
  // positions arithmetically.
  int          m_n;
  logic [15:0] m_shown, m_pend;
  bit          m_pvld;
  logic [3:0]  e_num;
  logic [3:0]  e_en;
  logic        e_fs;
  bit          model_ok = 0;

  always @(posedge clk) begin
    int  slot;
    int  nidx;
    bit  adv;
    bit  bnd;
    if (rst) begin
      m_n = 0; m_shown = '0; m_pend = '0; m_pvld = 0;
      e_num = 4'd0; e_en = 4'b0001; e_fs = 1'b0;
      model_ok = 1;
    end else if (model_ok) begin
      adv  = ((m_n + 1) % R) == 0;
      slot = (m_n + 1) / R;
      nidx = slot % N;
      bnd  = adv && (nidx == 0);
      if (bnd && m_pvld) begin
        m_shown = m_pend;
        m_pvld  = 0;
      end
      if (bus.load) begin
        m_pend = bus.value_in;
        m_pvld = 1;
      end
      e_fs = bnd;
      if (adv) begin
        e_en  = 4'(1 << nidx);
        e_num = ref_code(m_shown, nidx, bus.blank_lz);
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check_val("num", 32'(bus.num), 32'(e_num));
      check_val("digit_en", 32'(bus.digit_en), 32'(e_en));
      check_val("frame_start", 32'(bus.frame_start), 32'(e_fs));
    end
  end

  task automatic wait_fs();
    for (int i = 0; i < 4 * N * R + 8 && !bus.frame_start; i++) @(negedge clk);
    if (!bus.frame_start) check_val("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_en(input logic [3:0] target);
    for (int i = 0; i < 4 * N * R + 8 && bus.digit_en != target; i++) @(negedge clk);
    if (bus.digit_en != target) check_val("en_timeout", 32'(bus.digit_en), 32'(target));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  // Captures one frame; digit k's code ends up in nibble k.
  task automatic scan_frame(output logic [15:0] codes);
    wait_fs();
    codes[3:0] = bus.num;
    for (int k = 1; k < N; k++) begin
      repeat (R) @(negedge clk);
      codes[4*k +: 4] = bus.num;
    end
  endtask

  task automatic load_and_scan(input logic [15:0] v, input logic blz, output logic [15:0] codes);
    wait_fs();
    @(negedge clk);
    bus.blank_lz = blz;
    pulse_load(v);
    scan_frame(codes);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    int          len;
    if ($urandom_range(0, 1) == 0) begin
      v   = '0;
      len = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    end else begin
      v = 16'($urandom);
    end
    return v;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] codes;
    logic [15:0] part;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_num", 32'(bus.num), 32'd0);
    check_val("rst_en", 32'(bus.digit_en), 32'b0001);
    check_val("rst_fs", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;

    // Mid-frame reset.
    wait_en(4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_num", 32'(bus.num), 32'd0);
    check_val("midrst_en", 32'(bus.digit_en), 32'b0001);
    rst = 1'b0;
    repeat (R - 1) @(negedge clk);
    check_val("restart_hold_en", 32'(bus.digit_en), 32'b0001);
    @(negedge clk);
    check_val("restart_adv_en", 32'(bus.digit_en), 32'b0010);

    // Basic scan.
    load_and_scan(16'h1234, 1'b0, codes);
    check_val("scan_1234", 32'(codes), 32'h1234);

    // Tear-free update mid-frame.
    wait_fs();
    part[3:0] = bus.num;
    repeat (R) @(negedge clk);
    check_val("tear_slot1_en", 32'(bus.digit_en), 32'b0010);
    part[7:4] = bus.num;
    pulse_load(16'h5678);
    repeat (R - 1) @(negedge clk);
    part[11:8] = bus.num;
    repeat (R) @(negedge clk);
    part[15:12] = bus.num;
    check_val("tear_old_frame", 32'(part), 32'h1234);
    scan_frame(codes);
    check_val("tear_new_frame", 32'(codes), 32'h5678);

    // Blanking and non-BCD.
    load_and_scan(16'h0070, 1'b1, codes);
    check_val("blank_0070", 32'(codes), 32'hFF70);
    load_and_scan(16'h0000, 1'b1, codes);
    check_val("blank_0000", 32'(codes), 32'hFFF0);
    load_and_scan(16'h0070, 1'b0, codes);
    check_val("noblank_0070", 32'(codes), 32'h0070);
    load_and_scan(16'h00A5, 1'b0, codes);
    check_val("nonbcd_00A5", 32'(codes), 32'h00F5);

    // Last load in a frame wins.
    wait_fs();
    @(negedge clk);
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h2222);
    scan_frame(codes);
    check_val("last_load_wins", 32'(codes), 32'h2222);

    // Load exactly on a boundary edge while another value is pending.
    load_and_scan(16'h4444, 1'b0, codes);
    check_val("scan_4444", 32'(codes), 32'h4444);
    wait_fs();
    pulse_load(16'h2222);
    repeat (N * R - 2) @(negedge clk);
    pulse_load(16'h3333);
    check_val("race_fs", 32'(bus.frame_start), 32'd1);
    scan_frame(codes);
    check_val("race_first", 32'(codes), 32'h2222);
    scan_frame(codes);
    check_val("race_second", 32'(codes), 32'h3333);

    // Randomized phase; the per-cycle model comparison does the checking.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 299) == 0);
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.value_in = rand_val();
      if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
    end
    @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    repeat (2 * N * R) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
